// File: rtl/countdown_timer_if.sv
// Bus bundle between a controller and the MM:SS countdown timer.
//   master: drives tick/load/load_value/start/stop, observes the count and status.
//   slave : the timer itself.
// Packing of load_value and count_out: {min_tens, min_units, sec_tens, sec_units},
// with each digit in 4-bit BCD.
interface countdown_timer_if;
    logic        tick;
    logic        load;
    logic [15:0] load_value;
    logic        start;
    logic        stop;
    logic [15:0] count_out;
    logic        running;
    logic        done;
    logic        expired;
    logic        load_error;

    modport master (
        output tick, load, load_value, start, stop,
        input  count_out, running, done, expired, load_error
    );

    modport slave (
        input  tick, load, load_value, start, stop,
        output count_out, running, done, expired, load_error
    );
endinterface

// File: rtl/countdown_timer.sv
// Four-digit BCD MM:SS down-counter with load, start/stop and expiry flag.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - countdown_timer_if.slave:
//          tick, load, load_value[15:0], start, stop (inputs)
//          count_out[15:0], running, done, expired, load_error (registered outputs)
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | loaded or reset, waiting for start
// S_RUN   | decrementing one second per tick
// S_PAUSE | stopped mid-count, count held, start resumes
// S_DONE  | count reached 00:00, only load leaves
module countdown_timer #(
    parameter int SEC_UNITS_BASE = 10,
    parameter int SEC_TENS_BASE  = 6,
    parameter int MIN_UNITS_BASE = 10,
    parameter int MIN_TENS_BASE  = 6
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [4:0] SU_BASE = 5'(SEC_UNITS_BASE);
    localparam logic [4:0] ST_BASE = 5'(SEC_TENS_BASE);
    localparam logic [4:0] MU_BASE = 5'(MIN_UNITS_BASE);
    localparam logic [4:0] MT_BASE = 5'(MIN_TENS_BASE);

    localparam logic [3:0] SU_MAX = 4'(SEC_UNITS_BASE - 1);
    localparam logic [3:0] ST_MAX = 4'(SEC_TENS_BASE - 1);
    localparam logic [3:0] MU_MAX = 4'(MIN_UNITS_BASE - 1);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic        running_q, running_d;
    logic        done_q, done_d;
    logic        expired_q, expired_d;
    logic        load_error_q, load_error_d;

    // Load sanitation: any digit outside its modulus is forced to zero.
    logic [3:0] ld_su, ld_st, ld_mu, ld_mt;
    logic       bad_su, bad_st, bad_mu, bad_mt;
    logic [15:0] load_clean;

    always_comb begin
        bad_su = {1'b0, bus.load_value[3:0]}   >= SU_BASE;
        bad_st = {1'b0, bus.load_value[7:4]}   >= ST_BASE;
        bad_mu = {1'b0, bus.load_value[11:8]}  >= MU_BASE;
        bad_mt = {1'b0, bus.load_value[15:12]} >= MT_BASE;
        ld_su  = bad_su ? 4'd0 : bus.load_value[3:0];
        ld_st  = bad_st ? 4'd0 : bus.load_value[7:4];
        ld_mu  = bad_mu ? 4'd0 : bus.load_value[11:8];
        ld_mt  = bad_mt ? 4'd0 : bus.load_value[15:12];
        load_clean = {ld_mt, ld_mu, ld_st, ld_su};
    end

    // One-second decrement with ripple borrow. The all-zero case is never
    // fed through here because 00:01 is caught as expiry first.
    logic [3:0]  su, st, mu, mt;
    logic [3:0]  su_n, st_n, mu_n, mt_n;
    logic [15:0] count_dec;

    always_comb begin
        {mt, mu, st, su} = count_q;
        su_n = su;
        st_n = st;
        mu_n = mu;
        mt_n = mt;
        if (su != 4'd0) begin
            su_n = su - 4'd1;
        end else begin
            su_n = SU_MAX;
            if (st != 4'd0) begin
                st_n = st - 4'd1;
            end else begin
                st_n = ST_MAX;
                if (mu != 4'd0) begin
                    mu_n = mu - 4'd1;
                end else begin
                    mu_n = MU_MAX;
                    mt_n = mt - 4'd1;
                end
            end
        end
        count_dec = {mt_n, mu_n, st_n, su_n};
    end

    // Next-state logic; priority load > stop > start > tick.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        expired_d    = 1'b0;
        load_error_d = 1'b0;

        if (bus.load) begin
            state_d      = S_IDLE;
            count_d      = load_clean;
            load_error_d = bad_su | bad_st | bad_mu | bad_mt;
        end else if (bus.stop) begin
            if (state_q == S_RUN) begin
                state_d = S_PAUSE;
            end
        end else if (bus.start) begin
            if (state_q == S_IDLE || state_q == S_PAUSE) begin
                if (count_q != 16'h0000) begin
                    state_d = S_RUN;
                end else begin
                    state_d   = S_DONE;
                    expired_d = 1'b1;
                end
            end
        end else if (bus.tick && state_q == S_RUN) begin
            if (count_q == 16'h0001) begin
                state_d   = S_DONE;
                count_d   = 16'h0000;
                expired_d = 1'b1;
            end else begin
                count_d = count_dec;
            end
        end

        // Status flags are registered from the next state so they line up
        // with the state register.
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= 16'h0000;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            expired_q    <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            running_q    <= running_d;
            done_q       <= done_d;
            expired_q    <= expired_d;
            load_error_q <= load_error_d;
        end
    end

    assign bus.count_out  = count_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.expired    = expired_q;
    assign bus.load_error = load_error_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a random
// run compared against a reference model that tracks the count as a plain
// number of seconds.
module tb_countdown_timer;

    logic clk;
    logic rst;

    countdown_timer_if tif ();

    countdown_timer dut (
        .clk (clk),
        .rst (rst),
        .bus (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model
    localparam int MI = 0, MR = 1, MP = 2, MD = 3;
    int m_secs;
    int m_state;
    bit m_exp;
    bit m_lerr;

    function automatic logic [15:0] to_bcd(input int secs);
        int s;
        logic [3:0] su, st, mu, mt;
        s  = secs;
        su = 4'(s % 10); s = s / 10;
        st = 4'(s % 6);  s = s / 6;
        mu = 4'(s % 10); s = s / 10;
        mt = 4'(s % 6);
        return {mt, mu, st, su};
    endfunction

    task automatic model_reset();
        m_secs  = 0;
        m_state = MI;
        m_exp   = 0;
        m_lerr  = 0;
    endtask

    task automatic model_update(input logic ld, input logic [15:0] lv,
                                input logic st, input logic sp, input logic tk);
        int d [4];
        bit bad;
        int bases [4];
        bases = '{10, 6, 10, 6};
        m_exp  = 0;
        m_lerr = 0;
        if (ld) begin
            bad = 0;
            for (int i = 0; i < 4; i++) begin
                d[i] = int'(lv[i*4 +: 4]);
                if (d[i] >= bases[i]) begin
                    d[i] = 0;
                    bad  = 1;
                end
            end
            m_secs  = ((d[3] * 10 + d[2]) * 60) + d[1] * 10 + d[0];
            m_state = MI;
            m_lerr  = bad;
        end else if (sp) begin
            if (m_state == MR) m_state = MP;
        end else if (st) begin
            if (m_state == MI || m_state == MP) begin
                if (m_secs == 0) begin
                    m_state = MD;
                    m_exp   = 1;
                end else begin
                    m_state = MR;
                end
            end
        end else if (tk && m_state == MR) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
                m_state = MD;
                m_exp   = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, sample 1 ns later.
    task automatic cycle(input logic ld, input logic [15:0] lv,
                         input logic st, input logic sp, input logic tk);
        tif.load       = ld;
        tif.load_value = lv;
        tif.start      = st;
        tif.stop       = sp;
        tif.tick       = tk;
        @(posedge clk);
        model_update(ld, lv, st, sp, tk);
        #1;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        if (tif.count_out !== 16'h0000 || tif.running !== 1'b0 || tif.done !== 1'b0 ||
            tif.expired !== 1'b0 || tif.load_error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_initial got count=%h run=%b done=%b exp=%b lerr=%b want 0000/0/0/0/0",
                     tif.count_out, tif.running, tif.done, tif.expired, tif.load_error);
        end
        n_cmp++;

        cycle(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (tif.count_out !== 16'h1234 || tif.running !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_prerun got count=%h run=%b want 1234/1", tif.count_out, tif.running);
        end

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (tif.count_out !== 16'h0000 || tif.running !== 1'b0 || tif.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async got count=%h run=%b done=%b want 0000/0/0",
                     tif.count_out, tif.running, tif.done);
        end
        #2 rst = 1'b0;
        model_reset();

        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (tif.count_out !== 16'h0000 || tif.running !== 1'b0 || tif.done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ticks_idle got count=%h run=%b done=%b want 0000/0/0",
                     tif.count_out, tif.running, tif.done);
        end
    endtask

    task automatic test_borrow();
        cycle(1'b1, 16'h1000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (tif.count_out !== 16'h0959) begin
            n_bad++;
            $display("FAIL borrow_1000 got %h want 0959", tif.count_out);
        end

        cycle(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (tif.count_out !== 16'h0009 || tif.running !== 1'b1) begin
            n_bad++;
            $display("FAIL borrow_0010 got count=%h run=%b want 0009/1", tif.count_out, tif.running);
        end
    endtask

    task automatic test_expiry();
        cycle(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (tif.count_out !== 16'h0001 || tif.expired !== 1'b0) begin
            n_bad++;
            $display("FAIL expiry_0001 got count=%h exp=%b want 0001/0", tif.count_out, tif.expired);
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (tif.count_out !== 16'h0000 || tif.expired !== 1'b1 || tif.done !== 1'b1 ||
            tif.running !== 1'b0) begin
            n_bad++;
            $display("FAIL expiry_edge got count=%h exp=%b done=%b run=%b want 0000/1/1/0",
                     tif.count_out, tif.expired, tif.done, tif.running);
        end
        idle_cycle();
        n_cmp++;
        if (tif.expired !== 1'b0 || tif.done !== 1'b1) begin
            n_bad++;
            $display("FAIL expiry_pulse_width got exp=%b done=%b want 0/1", tif.expired, tif.done);
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (tif.count_out !== 16'h0000 || tif.done !== 1'b1 || tif.running !== 1'b0 ||
            tif.expired !== 1'b0) begin
            n_bad++;
            $display("FAIL expiry_sticky got count=%h done=%b run=%b exp=%b want 0000/1/0/0",
                     tif.count_out, tif.done, tif.running, tif.expired);
        end
    endtask

    task automatic test_pause_resume();
        cycle(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (tif.count_out !== 16'h0004) begin
            n_bad++;
            $display("FAIL pause_first_tick got %h want 0004", tif.count_out);
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (tif.count_out !== 16'h0004 || tif.running !== 1'b0 || tif.done !== 1'b0) begin
            n_bad++;
            $display("FAIL pause_stop_tick got count=%h run=%b done=%b want 0004/0/0",
                     tif.count_out, tif.running, tif.done);
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (tif.count_out !== 16'h0004 || tif.running !== 1'b1) begin
            n_bad++;
            $display("FAIL pause_start_tick got count=%h run=%b want 0004/1", tif.count_out, tif.running);
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (tif.count_out !== 16'h0003) begin
            n_bad++;
            $display("FAIL pause_resume_tick got %h want 0003", tif.count_out);
        end
    endtask

    task automatic test_load_sanitize();
        cycle(1'b1, 16'h7A59, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (tif.count_out !== 16'h0059 || tif.load_error !== 1'b1) begin
            n_bad++;
            $display("FAIL load_sanitize got count=%h lerr=%b want 0059/1", tif.count_out, tif.load_error);
        end
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (tif.load_error !== 1'b0 || tif.running !== 1'b1) begin
            n_bad++;
            $display("FAIL load_error_width got lerr=%b run=%b want 0/1", tif.load_error, tif.running);
        end
        cycle(1'b1, 16'h0321, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (tif.count_out !== 16'h0321 || tif.running !== 1'b0 || tif.done !== 1'b0 ||
            tif.load_error !== 1'b0) begin
            n_bad++;
            $display("FAIL load_priority got count=%h run=%b done=%b lerr=%b want 0321/0/0/0",
                     tif.count_out, tif.running, tif.done, tif.load_error);
        end
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (tif.count_out !== 16'h0321) begin
            n_bad++;
            $display("FAIL load_idle_tick got %h want 0321", tif.count_out);
        end
    endtask

    task automatic test_zero_start();
        sync_reset();
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (tif.done !== 1'b1 || tif.expired !== 1'b1 || tif.running !== 1'b0 ||
            tif.count_out !== 16'h0000) begin
            n_bad++;
            $display("FAIL zero_start got done=%b exp=%b run=%b count=%h want 1/1/0/0000",
                     tif.done, tif.expired, tif.running, tif.count_out);
        end
        idle_cycle();
        n_cmp++;
        if (tif.expired !== 1'b0 || tif.running !== 1'b0 || tif.done !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_start_after got exp=%b run=%b done=%b want 0/0/1",
                     tif.expired, tif.running, tif.done);
        end
    endtask

    task automatic test_random();
        logic        ld, st, sp, tk;
        logic [15:0] lv;
        logic [19:0] got, want;
        for (int i = 0; i < 600; i++) begin
            ld = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 14) == 0);
            tk = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0) lv = 16'($urandom);
            else                           lv = to_bcd($urandom_range(0, 130));
            cycle(ld, lv, st, sp, tk);
            got  = {tif.count_out, tif.running, tif.done, tif.expired, tif.load_error};
            want = {to_bcd(m_secs), m_state == MR, m_state == MD, m_exp, m_lerr};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL random_cycle_%0d got {count,run,done,exp,lerr}=%h want %h", i, got, want);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        tif.load       = 1'b0;
        tif.load_value = 16'h0000;
        tif.start      = 1'b0;
        tif.stop       = 1'b0;
        tif.tick       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_borrow();
        test_expiry();
        test_pause_resume();
        test_load_sanitize();
        test_zero_start();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
